// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter.
//   PORT_CPU / PORT_AUX : requester indices (CPU data side, loader/debug/DMA side)
//   DW_DEFAULT, STRB_W  : default data width and its byte-strobe width
//   strb_width()        : byte-strobe width for a given data width (DW/8)
//   run_cnt_width()     : width of the quantum run counter, clog2(QUANTUM+1)
package dmem_arbiter_pkg;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_AUX = 1'b1;

  localparam int DW_DEFAULT = 32;
  localparam int STRB_W     = DW_DEFAULT / 8;

  function automatic int strb_width(input int dw);
    return dw / 8;
  endfunction

  // The counter must be able to hold QUANTUM itself, where it saturates.
  function automatic int run_cnt_width(input int quantum);
    return $clog2(quantum + 1);
  endfunction

endpackage

// File: rtl/rr_quantum_arb.sv
// Two-way quantum-limited round-robin arbiter.
//   clk, reset  : clock, synchronous active-high reset
//   req[1:0]    : request per port
//   gnt[1:0]    : one-hot combinational grant (zero when nobody requests)
//   last_owner  : debug view of the port that received the most recent grant
//   run_cnt     : debug view of consecutive grants to last_owner (0 after an idle cycle)
// While both ports request, the current owner keeps the port for at most
// QUANTUM consecutive grants, then the other port takes over. A run that was
// broken by an idle cycle (run_cnt == 0) hands contention to the other port.
module rr_quantum_arb
  import dmem_arbiter_pkg::*;
#(
  parameter  int QUANTUM = 4,
  localparam int CW      = run_cnt_width(QUANTUM)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [1:0]    req,
  output logic [1:0]    gnt,
  output logic          last_owner,
  output logic [CW-1:0] run_cnt
);

  localparam logic [CW-1:0] QMAX = CW'(QUANTUM);

  logic any_req;
  logic keep_owner;
  logic sel;

  always_comb begin
    gnt        = 2'b00;
    any_req    = req[PORT_CPU] | req[PORT_AUX];
    keep_owner = (run_cnt != '0) && (run_cnt < QMAX);
    if (req[PORT_CPU] && req[PORT_AUX]) begin
      sel = keep_owner ? last_owner : ~last_owner;
    end else if (req[PORT_CPU]) begin
      sel = PORT_CPU;
    end else begin
      sel = PORT_AUX;
    end
    if (any_req) begin
      gnt[sel] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_owner <= PORT_AUX;
      run_cnt    <= '0;
    end else if (!any_req) begin
      // last_owner is kept so the next contention favours the other port.
      run_cnt <= '0;
    end else if (sel == last_owner) begin
      if (run_cnt != QMAX) begin
        run_cnt <= run_cnt + 1'b1;
      end
    end else begin
      last_owner <= sel;
      run_cnt    <= CW'(1);
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one synchronous-read data memory port between two requesters.
//   clk, reset                 : clock, synchronous active-high reset
//   req0/addr0/we0/wdata0      : CPU data-side request (we0 == 0 means read)
//   gnt0, rvalid0              : CPU grant this cycle, CPU read data on rdata
//   req1/addr1/we1/wdata1      : loader/debug/DMA request
//   gnt1, rvalid1              : aux grant, aux read data on rdata
//   rdata                      : shared read data, qualified by rvalid0/rvalid1
//   maddr/mwdata/mwe/mrd       : memory command, muxed from the granted port
//   mrdata                     : memory read data, valid the cycle after mrd
// Handshake: a request is accepted in the cycle where req and gnt are both
// high; until then the requester holds addr/we/wdata stable, and it may drop
// req at any time without consequence. Writes complete in the grant cycle with
// no response; reads return exactly one cycle after the grant, tagged by rvalid.
// While reset is high every output is forced to zero.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter  int AW      = 32,
  parameter  int DW      = 32,
  parameter  int QUANTUM = 4,
  localparam int SW      = strb_width(DW),
  localparam int CW      = run_cnt_width(QUANTUM)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0,
  input  logic [AW-1:0] addr0,
  input  logic [SW-1:0] we0,
  input  logic [DW-1:0] wdata0,
  output logic          gnt0,
  output logic          rvalid0,
  input  logic          req1,
  input  logic [AW-1:0] addr1,
  input  logic [SW-1:0] we1,
  input  logic [DW-1:0] wdata1,
  output logic          gnt1,
  output logic          rvalid1,
  output logic [DW-1:0] rdata,
  output logic [AW-1:0] maddr,
  output logic [DW-1:0] mwdata,
  output logic [SW-1:0] mwe,
  output logic          mrd,
  input  logic [DW-1:0] mrdata
);

  logic [1:0]    gnt_raw;
  logic          arb_last_owner;
  logic [CW-1:0] arb_run_cnt;

  logic          granted;
  logic          gport;
  logic [AW-1:0] maddr_raw;
  logic [DW-1:0] mwdata_raw;
  logic [SW-1:0] mwe_raw;
  logic          mrd_raw;

  logic          rd_pend;
  logic          rd_tag;

  rr_quantum_arb #(
    .QUANTUM (QUANTUM)
  ) u_arb (
    .clk        (clk),
    .reset      (reset),
    .req        ({req1, req0}),
    .gnt        (gnt_raw),
    .last_owner (arb_last_owner),
    .run_cnt    (arb_run_cnt)
  );

  always_comb begin
    granted    = gnt_raw[PORT_CPU] | gnt_raw[PORT_AUX];
    gport      = gnt_raw[PORT_AUX];
    maddr_raw  = '0;
    mwdata_raw = '0;
    mwe_raw    = '0;
    if (gnt_raw[PORT_AUX]) begin
      maddr_raw  = addr1;
      mwdata_raw = wdata1;
      mwe_raw    = we1;
    end else if (gnt_raw[PORT_CPU]) begin
      maddr_raw  = addr0;
      mwdata_raw = wdata0;
      mwe_raw    = we0;
    end
    // Any nonzero strobe mask is a write.
    mrd_raw = granted && (mwe_raw == '0);
  end

  // Read tag pipeline: remembers which port owns the data arriving next cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_pend <= 1'b0;
      rd_tag  <= PORT_CPU;
    end else begin
      rd_pend <= mrd_raw;
      rd_tag  <= gport;
    end
  end

  assign gnt0    = gnt_raw[PORT_CPU] & ~reset;
  assign gnt1    = gnt_raw[PORT_AUX] & ~reset;
  assign rvalid0 = rd_pend & (rd_tag == PORT_CPU) & ~reset;
  assign rvalid1 = rd_pend & (rd_tag == PORT_AUX) & ~reset;
  assign rdata   = reset ? '0 : mrdata;
  assign maddr   = reset ? '0 : maddr_raw;
  assign mwdata  = reset ? '0 : mwdata_raw;
  assign mwe     = reset ? '0 : mwe_raw;
  assign mrd     = mrd_raw & ~reset;

  // Arbitration invariants: one-hot grant, bounded run counter, and an
  // unfinished quantum under contention stays with the current owner.
  assert property (@(posedge clk) disable iff (reset)
    !(gnt_raw[0] && gnt_raw[1]) && (arb_run_cnt <= CW'(QUANTUM)));
  assert property (@(posedge clk) disable iff (reset)
    (req0 && req1 && (arb_run_cnt != '0) && (arb_run_cnt < CW'(QUANTUM)))
      |-> gnt_raw[arb_last_owner]);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: two instances (QUANTUM=4 and QUANTUM=1) share one
// stimulus stream; each has its own memory fixture and its own reference model.
module tb_dmem_arbiter;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // ---------------- shared stimulus ----------------
  logic        req0, req1;
  logic [31:0] addr0, addr1, wdata0, wdata1;
  logic [3:0]  we0, we1;

  // ---------------- instance a: QUANTUM = 4 ----------------
  logic        gnt0_a, gnt1_a, rvalid0_a, rvalid1_a, mrd_a;
  logic [31:0] rdata_a, maddr_a, mwdata_a;
  logic [31:0] mrdata_a = '0;
  logic [3:0]  mwe_a;

  dmem_arbiter #(.AW(32), .DW(32), .QUANTUM(4)) dut_a (
    .clk(clk), .reset(reset),
    .req0(req0), .addr0(addr0), .we0(we0), .wdata0(wdata0), .gnt0(gnt0_a), .rvalid0(rvalid0_a),
    .req1(req1), .addr1(addr1), .we1(we1), .wdata1(wdata1), .gnt1(gnt1_a), .rvalid1(rvalid1_a),
    .rdata(rdata_a), .maddr(maddr_a), .mwdata(mwdata_a), .mwe(mwe_a), .mrd(mrd_a),
    .mrdata(mrdata_a)
  );

  // ---------------- instance b: QUANTUM = 1 ----------------
  logic        gnt0_b, gnt1_b, rvalid0_b, rvalid1_b, mrd_b;
  logic [31:0] rdata_b, maddr_b, mwdata_b;
  logic [31:0] mrdata_b = '0;
  logic [3:0]  mwe_b;

  dmem_arbiter #(.AW(32), .DW(32), .QUANTUM(1)) dut_b (
    .clk(clk), .reset(reset),
    .req0(req0), .addr0(addr0), .we0(we0), .wdata0(wdata0), .gnt0(gnt0_b), .rvalid0(rvalid0_b),
    .req1(req1), .addr1(addr1), .we1(we1), .wdata1(wdata1), .gnt1(gnt1_b), .rvalid1(rvalid1_b),
    .rdata(rdata_b), .maddr(maddr_b), .mwdata(mwdata_b), .mwe(mwe_b), .mrd(mrd_b),
    .mrdata(mrdata_b)
  );

  // ---------------- memory fixtures (fixed preload, synchronous read) ----------------
  function automatic logic [31:0] mem_val(input logic [31:0] a);
    case (a)
      32'h0000_0040: return 32'hDEAD_BEEF;
      32'h0000_0010: return 32'h1111_0010;
      32'h0000_0020: return 32'h2222_0020;
      default:       return a ^ 32'h5A5A_0000;
    endcase
  endfunction

  always @(posedge clk) if (mrd_a) mrdata_a <= mem_val(maddr_a);
  always @(posedge clk) if (mrd_b) mrdata_b <= mem_val(maddr_b);

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  logic [1:0]  gnt_s   [2];
  logic [1:0]  rv_s    [2];
  logic [31:0] rdata_s [2];
  logic [31:0] maddr_s [2];
  logic [31:0] mwdata_s[2];
  logic [3:0]  mwe_s   [2];
  logic        mrd_s   [2];

  assign gnt_s[0]    = {gnt1_a, gnt0_a};
  assign gnt_s[1]    = {gnt1_b, gnt0_b};
  assign rv_s[0]     = {rvalid1_a, rvalid0_a};
  assign rv_s[1]     = {rvalid1_b, rvalid0_b};
  assign rdata_s[0]  = rdata_a;
  assign rdata_s[1]  = rdata_b;
  assign maddr_s[0]  = maddr_a;
  assign maddr_s[1]  = maddr_b;
  assign mwdata_s[0] = mwdata_a;
  assign mwdata_s[1] = mwdata_b;
  assign mwe_s[0]    = mwe_a;
  assign mwe_s[1]    = mwe_b;
  assign mrd_s[0]    = mrd_a;
  assign mrd_s[1]    = mrd_b;

  // Reference model: who owned the memory last and for how many cycles in a row.
  localparam int QV [2] = '{4, 1};
  logic m_last   [2] = '{1'b1, 1'b1};
  int   m_streak [2] = '{0, 0};
  // Outstanding reads: {port, expected data}, one queue per instance.
  logic [32:0] exp_q0[$];
  logic [32:0] exp_q1[$];

  task automatic check_inst(input int k);
    string       p;
    logic [32:0] e;
    logic        have, any, sel, erd;
    logic [1:0]  eg, erv;
    logic [31:0] ea, ed;
    logic [3:0]  ew;
    p = (k == 0) ? "q4" : "q1";
    if (reset) begin
      chk($sformatf("%s rst gnt", p),    64'(gnt_s[k]),    64'd0);
      chk($sformatf("%s rst rvalid", p), 64'(rv_s[k]),     64'd0);
      chk($sformatf("%s rst rdata", p),  64'(rdata_s[k]),  64'd0);
      chk($sformatf("%s rst maddr", p),  64'(maddr_s[k]),  64'd0);
      chk($sformatf("%s rst mwdata", p), 64'(mwdata_s[k]), 64'd0);
      chk($sformatf("%s rst mwe", p),    64'(mwe_s[k]),    64'd0);
      chk($sformatf("%s rst mrd", p),    64'(mrd_s[k]),    64'd0);
      m_last[k]   = 1'b1;
      m_streak[k] = 0;
      if (k == 0) exp_q0.delete(); else exp_q1.delete();
      return;
    end
    // read data owed from last cycle
    have = 1'b0;
    e    = '0;
    if (k == 0) begin
      if (exp_q0.size() > 0) begin e = exp_q0.pop_front(); have = 1'b1; end
    end else begin
      if (exp_q1.size() > 0) begin e = exp_q1.pop_front(); have = 1'b1; end
    end
    erv = !have ? 2'b00 : (e[32] ? 2'b10 : 2'b01);
    chk($sformatf("%s rvalid", p), 64'(rv_s[k]), 64'(erv));
    if (have) chk($sformatf("%s rdata", p), 64'(rdata_s[k]), 64'(e[31:0]));
    // this cycle's grant
    any = req0 | req1;
    if (req0 && req1)
      sel = (m_streak[k] > 0 && m_streak[k] < QV[k]) ? m_last[k] : !m_last[k];
    else
      sel = req1;
    eg = 2'b00; ea = '0; ed = '0; ew = '0; erd = 1'b0;
    if (any) begin
      eg  = sel ? 2'b10 : 2'b01;
      ea  = sel ? addr1 : addr0;
      ed  = sel ? wdata1 : wdata0;
      ew  = sel ? we1 : we0;
      erd = (ew == 4'b0000);
    end
    chk($sformatf("%s gnt", p),    64'(gnt_s[k]),    64'(eg));
    chk($sformatf("%s maddr", p),  64'(maddr_s[k]),  64'(ea));
    chk($sformatf("%s mwdata", p), 64'(mwdata_s[k]), 64'(ed));
    chk($sformatf("%s mwe", p),    64'(mwe_s[k]),    64'(ew));
    chk($sformatf("%s mrd", p),    64'(mrd_s[k]),    64'(erd));
    if (any) begin
      if (sel == m_last[k]) m_streak[k]++;
      else begin m_last[k] = sel; m_streak[k] = 1; end
    end else begin
      m_streak[k] = 0;
    end
    if (erd) begin
      if (k == 0) exp_q0.push_back({sel, mem_val(ea)});
      else        exp_q1.push_back({sel, mem_val(ea)});
    end
  endtask

  always @(negedge clk) begin
    check_inst(0);
    check_inst(1);
  end

  // ---------------- driver ----------------
  task automatic drive(input logic rst,
                       input logic r0, input logic [31:0] a0, input logic [3:0] w0, input logic [31:0] d0,
                       input logic r1, input logic [31:0] a1, input logic [3:0] w1, input logic [31:0] d1);
    @(posedge clk);
    #1;
    reset = rst;
    req0 = r0; addr0 = a0; we0 = w0; wdata0 = d0;
    req1 = r1; addr1 = a1; we1 = w1; wdata1 = d1;
    @(negedge clk);
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 32'h0, 4'h0, 32'h0);
  endtask

  logic [8:0] seq_a;
  logic [8:0] seq_b;

  initial begin
    reset = 1'b1;
    req0 = 1'b1; addr0 = 32'h10; we0 = 4'h0; wdata0 = '0;
    req1 = 1'b1; addr1 = 32'h20; we1 = 4'h0; wdata1 = '0;

    // Reset held with both requesting: everything gated off.
    repeat (3) begin
      drive(1'b1, 1'b1, 32'h10, 4'h0, 32'h0, 1'b1, 32'h20, 4'h0, 32'h0);
      chk("rst gnt0", 64'(gnt0_a), 64'd0);
      chk("rst gnt1", 64'(gnt1_a), 64'd0);
      chk("rst mwe",  64'(mwe_a),  64'd0);
      chk("rst mrd",  64'(mrd_a),  64'd0);
      chk("rst rvalid", 64'({rvalid1_a, rvalid0_a}), 64'd0);
    end

    // Continuous contention from reset: bit i = port granted in cycle i.
    seq_a = 9'b0_1111_0000;
    seq_b = 9'b0_1010_1010;
    for (int i = 0; i < 9; i++) begin
      drive(1'b0, 1'b1, 32'h10, 4'h0, 32'h0, 1'b1, 32'h20, 4'h0, 32'h0);
      chk($sformatf("cont q4 gnt1 #%0d", i), 64'(gnt1_a), 64'(seq_a[i]));
      chk($sformatf("cont q4 gnt0 #%0d", i), 64'(gnt0_a), 64'(!seq_a[i]));
      chk($sformatf("cont q1 gnt1 #%0d", i), 64'(gnt1_b), 64'(seq_b[i]));
      if (i > 0) begin
        chk($sformatf("alt q1 rvalid #%0d", i), 64'({rvalid1_b, rvalid0_b}),
            seq_b[i-1] ? 64'h2 : 64'h1);
        chk($sformatf("alt q1 rdata #%0d", i), 64'(rdata_b),
            seq_b[i-1] ? 64'h2222_0020 : 64'h1111_0010);
      end
    end
    idle();

    // Solo read from port 0.
    drive(1'b0, 1'b1, 32'h40, 4'h0, 32'h0, 1'b0, 32'h0, 4'h0, 32'h0);
    chk("solo rd gnt0",  64'(gnt0_a),  64'd1);
    chk("solo rd gnt1",  64'(gnt1_a),  64'd0);
    chk("solo rd maddr", 64'(maddr_a), 64'h40);
    chk("solo rd mrd",   64'(mrd_a),   64'd1);
    idle();
    chk("solo rd rvalid0", 64'(rvalid0_a), 64'd1);
    chk("solo rd rvalid1", 64'(rvalid1_a), 64'd0);
    chk("solo rd rdata",   64'(rdata_a),   64'hDEAD_BEEF);

    // Solo partial write from port 1.
    drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 32'h80, 4'b0011, 32'h1234_ABCD);
    chk("solo wr gnt1",   64'(gnt1_a),   64'd1);
    chk("solo wr mwe",    64'(mwe_a),    64'h3);
    chk("solo wr maddr",  64'(maddr_a),  64'h80);
    chk("solo wr mwdata", 64'(mwdata_a), 64'h1234_ABCD);
    chk("solo wr mrd",    64'(mrd_a),    64'd0);
    idle();
    chk("solo wr no rvalid", 64'({rvalid1_a, rvalid0_a}), 64'd0);

    // Saturation: port 0 alone for 6 cycles, then port 1 joins and wins at once.
    repeat (6) drive(1'b0, 1'b1, 32'h44, 4'h0, 32'h0, 1'b0, 32'h0, 4'h0, 32'h0);
    drive(1'b0, 1'b1, 32'h44, 4'h0, 32'h0, 1'b1, 32'h24, 4'h0, 32'h0);
    chk("sat gnt1", 64'(gnt1_a), 64'd1);
    chk("sat gnt0", 64'(gnt0_a), 64'd0);
    repeat (5) drive(1'b0, 1'b1, 32'h44, 4'h0, 32'h0, 1'b1, 32'h24, 4'h0, 32'h0);
    idle();

    // Reset on the cycle after a port-1 read: its data never shows up.
    drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 32'h20, 4'h0, 32'h0);
    chk("rmr gnt1", 64'(gnt1_a), 64'd1);
    chk("rmr mrd",  64'(mrd_a),  64'd1);
    drive(1'b1, 1'b1, 32'h10, 4'h0, 32'h0, 1'b1, 32'h20, 4'h0, 32'h0);
    chk("rmr rvalid1 in reset", 64'(rvalid1_a), 64'd0);
    chk("rmr q1 rvalid1 in reset", 64'(rvalid1_b), 64'd0);
    idle();
    chk("rmr rvalid1 after", 64'(rvalid1_a), 64'd0);
    drive(1'b0, 1'b1, 32'h10, 4'h0, 32'h0, 1'b1, 32'h20, 4'h0, 32'h0);
    chk("rmr post gnt0 q4", 64'(gnt0_a), 64'd1);
    chk("rmr post gnt0 q1", 64'(gnt0_b), 64'd1);

    // Mixed traffic checked by the model alone.
    for (int i = 0; i < 40; i++) begin
      drive(1'b0,
            1'($urandom_range(0, 1)), 32'($urandom_range(0, 7)) << 4,
            ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15)), $urandom,
            1'($urandom_range(0, 1)), 32'($urandom_range(0, 7)) << 4,
            ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15)), $urandom);
    end
    idle();
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
